// File: rtl/clkgen_pkg.sv
// Shared defaults and helpers for the multi-channel clock generator.
// Channel-select width is derived from the channel count by chan_width().
package clkgen_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DIV_W    = 16;
  localparam int DEF_HALF     = 10;
  localparam bit DEF_RUN      = 1'b1;

  // A single channel still needs a one-bit select so the port never collapses.
  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/multi_clock_channel.sv
// One divided-clock channel: half-period counter, output flops and a single
// pending config slot that is only applied at a falling toggle or while stopped.
module multi_clock_channel #(
  parameter int               DIV_W        = 16,
  parameter logic [DIV_W-1:0] DEFAULT_HALF = DIV_W'(10),
  parameter bit               DEFAULT_RUN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DIV_W-1:0] load_half_i,
  input  logic             load_run_i,
  output logic             ch_clk_o,
  output logic             ch_tick_o,
  output logic             running_o,
  output logic             pending_o
);

  typedef struct packed {
    logic [DIV_W-1:0] half;
    logic             run;
  } cfg_rec_t;

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             run_q, run_d;
  logic             pend_q, pend_d;
  cfg_rec_t         slot_q, slot_d;

  logic wrap;
  logic apply;
  logic new_run;

  assign wrap    = run_q && (cnt_q == half_q - DIV_W'(1));
  assign apply   = pend_q && (!run_q || (wrap && clk_q));
  assign new_run = slot_q.run && (slot_q.half != '0);

  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    run_d  = run_q;
    pend_d = pend_q;
    slot_d = slot_q;

    if (run_q) begin
      if (wrap) begin
        cnt_d  = '0;
        clk_d  = !clk_q;
        tick_d = !clk_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    // A zero half-period means stop, and the previous half-period is retained.
    if (apply) begin
      pend_d = 1'b0;
      cnt_d  = '0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
      run_d  = new_run;
      if (slot_q.half != '0) begin
        half_d = slot_q.half;
      end
    end

    if (load_i && !pend_q) begin
      pend_d      = 1'b1;
      slot_d.half = load_half_i;
      slot_d.run  = load_run_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      half_q <= DEFAULT_HALF;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      run_q  <= DEFAULT_RUN;
      pend_q <= 1'b0;
      slot_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
      run_q  <= run_d;
      pend_q <= pend_d;
      slot_q <= slot_d;
    end
  end

  assign ch_clk_o  = clk_q;
  assign ch_tick_o = tick_q;
  assign running_o = run_q;
  assign pending_o = pend_q;

endmodule

// File: rtl/multi_clock_generator.sv
// Parametrised bank of glitch-free divided clocks with a valid/ready config port.
// Requests to channels that do not exist are accepted and dropped.
module multi_clock_generator
  import clkgen_pkg::*;
#(
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int DIV_W        = DEF_DIV_W,
  parameter int DEFAULT_HALF = DEF_HALF,
  parameter bit DEFAULT_RUN  = DEF_RUN,
  localparam int CW          = chan_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CW-1:0]       cfg_chan,
  input  logic [DIV_W-1:0]    cfg_half,
  input  logic                cfg_run,
  output logic [CHANNELS-1:0] ch_clk,
  output logic [CHANNELS-1:0] ch_tick,
  output logic [CHANNELS-1:0] ch_running
);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] load;

  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CW'(i)) begin
        cfg_ready = !pend[i];
      end
    end
  end

  always_comb begin
    load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      load[i] = cfg_valid && cfg_ready && (cfg_chan == CW'(i));
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    multi_clock_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_HALF(DIV_W'(DEFAULT_HALF)),
      .DEFAULT_RUN (DEFAULT_RUN)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load[g]),
      .load_half_i(cfg_half),
      .load_run_i (cfg_run),
      .ch_clk_o   (ch_clk[g]),
      .ch_tick_o  (ch_tick[g]),
      .running_o  (ch_running[g]),
      .pending_o  (pend[g])
    );
  end

endmodule

// File: tb/tb_multi_clock_generator.sv
// Bench for multi_clock_generator: a reset/free-run vector table, then
// config sequences whose expected phase lengths are scoreboarded per channel.
module tb_multi_clock_generator;

  localparam int CHANNELS = 5;
  localparam int DIV_W    = 16;
  localparam int CW       = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cfg_valid;
  logic                cfg_ready;
  logic [CW-1:0]       cfg_chan;
  logic [DIV_W-1:0]    cfg_half;
  logic                cfg_run;
  logic [CHANNELS-1:0] ch_clk;
  logic [CHANNELS-1:0] ch_tick;
  logic [CHANNELS-1:0] ch_running;

  int nVec = 0;
  int nFail = 0;
  int cyc = 0;

  typedef struct {
    int   chan;
    logic level;
    int   len;
  } sbEntry_t;

  typedef struct {
    int                  cyc;
    logic [CW-1:0]       chan;
    logic [CHANNELS-1:0] clkExp;
    logic [CHANNELS-1:0] tickExp;
    logic [CHANNELS-1:0] runExp;
    logic                readyExp;
  } vec_t;

  sbEntry_t            sbq[$];
  vec_t                vecs[$];
  logic [CHANNELS-1:0] prevClk;
  int                  lastChange[CHANNELS];
  int                  monIdx;
  int                  acc;

  multi_clock_generator #(
    .CHANNELS    (CHANNELS),
    .DIV_W       (DIV_W),
    .DEFAULT_HALF(10),
    .DEFAULT_RUN (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_half  (cfg_half),
    .cfg_run   (cfg_run),
    .ch_clk    (ch_clk),
    .ch_tick   (ch_tick),
    .ch_running(ch_running)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) step();
  endtask

  task automatic expectPhase(input int chan, input logic level, input int len);
    sbEntry_t e;
    e.chan  = chan;
    e.level = level;
    e.len   = len;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input int chan, input int half, input logic run, output int acceptedAt);
    int waited = 0;
    cfg_chan  = CW'(chan);
    cfg_half  = DIV_W'(half);
    cfg_run   = run;
    cfg_valid = 1'b1;
    #1;
    while (cfg_ready !== 1'b1 && waited < 40) begin
      step();
      waited++;
    end
    if (cfg_ready !== 1'b1) checkOutput("cfg_ready wait timeout", cfg_ready, 1);
    step();
    cfg_valid  = 1'b0;
    acceptedAt = cyc;
  endtask

  // Each observed ch_clk transition is matched against the oldest expectation for that channel.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevClk = '0;
      for (int i = 0; i < CHANNELS; i++) lastChange[i] = 0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_clk[i] !== prevClk[i]) begin
          monIdx = -1;
          for (int k = 0; k < sbq.size(); k++) begin
            if (monIdx < 0 && sbq[k].chan == i) monIdx = k;
          end
          if (monIdx >= 0) begin
            checkOutput($sformatf("ch%0d new level", i), ch_clk[i], sbq[monIdx].level);
            checkOutput($sformatf("ch%0d phase length", i), cyc - lastChange[i], sbq[monIdx].len);
            checkOutput($sformatf("ch%0d tick at edge", i), ch_tick[i], sbq[monIdx].level);
            sbq.delete(monIdx);
          end
          lastChange[i] = cyc;
        end
      end
      prevClk = ch_clk;
    end
  end

  initial begin
    vecs.push_back('{0,   3'd0, 5'h00, 5'h00, 5'h1F, 1'b1});
    vecs.push_back('{9,   3'd1, 5'h00, 5'h00, 5'h1F, 1'b1});
    vecs.push_back('{10,  3'd2, 5'h1F, 5'h1F, 5'h1F, 1'b1});
    vecs.push_back('{11,  3'd3, 5'h1F, 5'h00, 5'h1F, 1'b1});
    vecs.push_back('{19,  3'd4, 5'h1F, 5'h00, 5'h1F, 1'b1});
    vecs.push_back('{20,  3'd7, 5'h00, 5'h00, 5'h1F, 1'b1});
    vecs.push_back('{29,  3'd0, 5'h00, 5'h00, 5'h1F, 1'b1});
    vecs.push_back('{30,  3'd1, 5'h1F, 5'h1F, 5'h1F, 1'b1});
    vecs.push_back('{50,  3'd2, 5'h1F, 5'h1F, 5'h1F, 1'b1});
    vecs.push_back('{100, 3'd3, 5'h00, 5'h00, 5'h1F, 1'b1});
    vecs.push_back('{110, 3'd4, 5'h1F, 5'h1F, 5'h1F, 1'b1});
    vecs.push_back('{199, 3'd0, 5'h1F, 5'h00, 5'h1F, 1'b1});
    vecs.push_back('{200, 3'd1, 5'h00, 5'h00, 5'h1F, 1'b1});

    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_chan  = '0;
    cfg_half  = '0;
    cfg_run   = 1'b0;
    repeat (3) step();
    checkOutput("reset ch_clk", ch_clk, 0);
    checkOutput("reset ch_tick", ch_tick, 0);
    checkOutput("reset ch_running", ch_running, 5'h1F);
    checkOutput("reset cfg_ready", cfg_ready, 1);
    rst_n = 1'b1;
    cyc   = 0;

    // Free run at the default half-period of 10.
    foreach (vecs[v]) begin
      waitCycle(vecs[v].cyc);
      cfg_chan = vecs[v].chan;
      #1;
      checkOutput($sformatf("vec%0d ch_clk", v), ch_clk, vecs[v].clkExp);
      checkOutput($sformatf("vec%0d ch_tick", v), ch_tick, vecs[v].tickExp);
      checkOutput($sformatf("vec%0d ch_running", v), ch_running, vecs[v].runExp);
      checkOutput($sformatf("vec%0d cfg_ready", v), cfg_ready, vecs[v].readyExp);
    end

    // ch1 -> half 3 mid high phase; the others keep period 20.
    waitCycle(213);
    expectPhase(1, 1'b0, 10);
    expectPhase(1, 1'b1, 3);
    expectPhase(1, 1'b0, 3);
    expectPhase(1, 1'b1, 3);
    for (int c = 0; c < CHANNELS; c++) begin
      if (c != 1) begin
        expectPhase(c, 1'b0, 10);
        expectPhase(c, 1'b1, 10);
      end
    end
    applyStimulus(1, 3, 1'b1, acc);
    checkOutput("ch1 accept cycle", acc, 214);
    checkOutput("ch1 ready while pending", cfg_ready, 0);
    waitCycle(219);
    checkOutput("ch1 ready before apply", cfg_ready, 0);
    waitCycle(220);
    checkOutput("ch1 ready after apply", cfg_ready, 1);

    // ch2 stop, then restart at half 1.
    waitCycle(232);
    expectPhase(2, 1'b0, 10);
    expectPhase(2, 1'b1, 3);
    expectPhase(2, 1'b0, 1);
    expectPhase(2, 1'b1, 1);
    expectPhase(2, 1'b0, 1);
    applyStimulus(2, 10, 1'b0, acc);
    checkOutput("ch2 stop accept cycle", acc, 233);
    applyStimulus(2, 1, 1'b1, acc);
    checkOutput("ch2 restart accept cycle", acc, 241);
    checkOutput("ch2 stopped", ch_running[2], 0);
    waitCycle(242);
    checkOutput("ch2 running after apply", ch_running[2], 1);
    checkOutput("ch2 low at apply", ch_clk[2], 0);
    waitCycle(243);
    checkOutput("ch2 first rise", ch_clk[2], 1);
    checkOutput("ch2 first tick", ch_tick[2], 1);

    // ch0 half 0 acts as stop, then half 5 from the stopped state.
    waitCycle(246);
    expectPhase(0, 1'b1, 10);
    expectPhase(0, 1'b0, 10);
    expectPhase(0, 1'b1, 7);
    expectPhase(0, 1'b0, 5);
    applyStimulus(0, 0, 1'b1, acc);
    checkOutput("ch0 zero-half accept cycle", acc, 247);
    applyStimulus(0, 5, 1'b1, acc);
    checkOutput("ch0 restart accept cycle", acc, 261);
    checkOutput("ch0 stopped by zero half", ch_running[0], 0);
    waitCycle(262);
    checkOutput("ch0 running after apply", ch_running[0], 1);
    waitCycle(266);
    checkOutput("ch0 still low", ch_clk[0], 0);
    waitCycle(267);
    checkOutput("ch0 rise 5 after apply", ch_clk[0], 1);
    checkOutput("ch0 tick 5 after apply", ch_tick[0], 1);

    // ch3 back-to-back writes, then a write to a nonexistent channel.
    waitCycle(268);
    expectPhase(3, 1'b1, 10);
    expectPhase(3, 1'b0, 10);
    expectPhase(3, 1'b1, 4);
    expectPhase(3, 1'b0, 4);
    expectPhase(3, 1'b1, 6);
    expectPhase(3, 1'b0, 6);
    applyStimulus(3, 4, 1'b1, acc);
    checkOutput("ch3 first accept cycle", acc, 269);
    applyStimulus(3, 6, 1'b1, acc);
    checkOutput("ch3 second accept cycle", acc, 281);
    applyStimulus(7, 2, 1'b0, acc);
    checkOutput("chan7 accept cycle", acc, 282);
    waitCycle(285);
    checkOutput("running after chan7 write", ch_running, 5'h1F);
    waitCycle(302);

    // Reset during ch4's high phase with a write pending.
    waitCycle(311);
    applyStimulus(4, 2, 1'b1, acc);
    checkOutput("ch4 accept cycle", acc, 312);
    checkOutput("ch4 ready while pending", cfg_ready, 0);
    waitCycle(313);
    checkOutput("ch4 high before reset", ch_clk[4], 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset ch_clk", ch_clk, 0);
    checkOutput("async reset ch_tick", ch_tick, 0);
    checkOutput("async reset ch_running", ch_running, 5'h1F);
    checkOutput("async reset ch4 ready", cfg_ready, 1);
    step();
    step();
    rst_n = 1'b1;
    cyc   = 0;
    for (int c = 0; c < CHANNELS; c++) begin
      expectPhase(c, 1'b1, 10);
      expectPhase(c, 1'b0, 10);
    end
    waitCycle(10);
    checkOutput("post-reset rise ch_clk", ch_clk, 5'h1F);
    checkOutput("post-reset rise ch_tick", ch_tick, 5'h1F);
    waitCycle(20);
    checkOutput("post-reset fall ch_clk", ch_clk, 0);
    waitCycle(22);

    foreach (sbq[k]) begin
      nVec++;
      nFail++;
      $display("[TB] FAIL scoreboard ch%0d: transition never seen, got none, expected level %0d after %0d cycles",
               sbq[k].chan, sbq[k].level, sbq[k].len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
